// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: state encoding and constants shared by the fetch path.
package fetch_pkg;
  typedef enum logic [2:0] {F0, F1, F2, F3, HOLD, ERR} state_t;
  localparam int BYTES_PER_INSTR = 4;
  localparam int JUMP_IDX_W = 26;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory byte port plus decode handshake and redirect inputs.
interface fetch_sequencer_if;
  import fetch_pkg::*;
  logic [31:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  logic branch_en;
  logic [31:0] branch_off;
  logic jump_en;
  logic [JUMP_IDX_W-1:0] jump_target;
  logic fetch_err;
  modport master (
    output mem_addr, mem_rd, instr, instr_pc, instr_valid, fetch_err,
    input mem_rdata, instr_ready, branch_en, branch_off, jump_en, jump_target
  );
  modport slave (
    input mem_addr, mem_rd, instr, instr_pc, instr_valid, fetch_err,
    output mem_rdata, instr_ready, branch_en, branch_off, jump_en, jump_target
  );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next PC; jump beats branch beats sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic branch_en,
  input  logic [31:0] branch_off,
  input  logic jump_en,
  input  logic [JUMP_IDX_W-1:0] jump_target,
  output logic [31:0] next_pc
);
  logic [31:0] pc4;
  assign pc4 = pc + 32'(BYTES_PER_INSTR);
  assign next_pc = jump_en ? {pc4[31:28], jump_target, 2'b00} :
                   branch_en ? pc4 + (branch_off << 2) : pc4;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: four-cycle byte-wise instruction fetch with decode handshake.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUND_CHK_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int MEM_BYTES = 1000
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
`ifdef FETCH_BOUND_CHK_EN
  localparam bit BOUND_CHK = 1'b1;
`else
  localparam bit BOUND_CHK = 1'b0;
`endif
  state_t state, state_n;
  logic [31:0] pc, next_pc, addr, instr;
  logic [1:0] k;
  logic fetching, hs, oob;
  assign k = 2'(state);
  assign fetching = state inside {F0, F1, F2, F3};
  assign hs = state == HOLD && bus.instr_ready;
  assign oob = BOUND_CHK && ({1'b0, next_pc} + 33'd3 >= 33'(MEM_BYTES));
  next_pc_calc u_npc (
    .pc(pc),
    .branch_en(bus.branch_en),
    .branch_off(bus.branch_off),
    .jump_en(bus.jump_en),
    .jump_target(bus.jump_target),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk) state <= rst ? F0 : state_n;
  always_comb begin
    state_n = state;
    case (state)
      F0: state_n = F1;
      F1: state_n = F2;
      F2: state_n = F3;
      F3: state_n = HOLD;
      HOLD: state_n = hs ? (oob ? ERR : F0) : HOLD;
`ifdef FETCH_BOUND_CHK_EN
      ERR: state_n = ERR;
`endif
      default: state_n = F0;
    endcase
  end
  // addr walks pc..pc+3 during the fetch and then holds pc+3 while mem_rd is low
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      addr <= RESET_PC;
      instr <= '0;
    end else begin
      if (fetching) begin
        instr[{~k, 3'b000} +: 8] <= bus.mem_rdata;
        if (state != F3) addr <= addr + 32'd1;
      end
      if (hs) begin
        pc <= next_pc;
        if (!oob) addr <= next_pc;
      end
    end
  end
  assign bus.mem_addr = addr;
  assign bus.mem_rd = fetching && !rst;
  assign bus.instr = instr;
  assign bus.instr_pc = pc;
  assign bus.instr_valid = state == HOLD;
`ifdef FETCH_BOUND_CHK_EN
  assign bus.fetch_err = state == ERR;
`else
  assign bus.fetch_err = 1'b0;
`endif
endmodule
